// File: rtl/compound_port_arbiter_pkg.sv
// Shared types for the compound-port arbiter: payload record, FSM states and
// the round-robin search used by the priority picker.
package compound_port_arbiter_types;

    localparam int unsigned MAX_N     = 16;
    localparam int unsigned IDX_MAX_W = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] payload;
    } compound_t;

    localparam int unsigned COMPOUND_W = $bits(compound_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } pick_t;

    // Rotate so last+1 is the lowest position, find first set, rotate back.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]     req,
                                      input logic [IDX_MAX_W-1:0] last,
                                      input int unsigned          n);
        pick_t       res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            pos = (32'(last) + 32'd1 + k) % n;
            if (!res.found && (k < n) && req[IDX_MAX_W'(pos)]) begin
                res.found = 1'b1;
                res.idx   = IDX_MAX_W'(pos);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/compound_port_arbiter_picker.sv
// Combinational round-robin picker: first active request after last_i,
// wrapping at N.
module rr_priority_picker
    import compound_port_arbiter_types::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             found_c_o
);

    pick_t pick_c;

    always_comb begin
        pick_c    = rr_pick(MAX_N'(req_i), IDX_MAX_W'(last_i), N);
        idx_c_o   = IDX_W'(pick_c.idx);
        found_c_o = pick_c.found;
    end

endmodule

// File: rtl/compound_port_arbiter.sv
// Round-robin arbiter sharing one blocking compound output port between N
// requesters through a one-entry holding register.
module compound_port_arbiter
    import compound_port_arbiter_types::*;
#(
    parameter  int unsigned N      = 4,
    parameter  int unsigned DATA_W = COMPOUND_W,
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATA_W-1:0]   req_data_i,
    input  logic [N-1:0]          req_notify_i,
    output logic [N-1:0]          req_sync_o,
    output logic [DATA_W-1:0]     b_out_o,
    input  logic                  b_out_sync_i,
    output logic                  b_out_notify_o,
    output logic [IDX_W-1:0]      grant_id_o,
    output logic                  busy_o
);

    state_e            state_q;
    logic [DATA_W-1:0] b_out_q;
    logic              notify_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_q;

    logic [IDX_W-1:0]  win_c;
    logic              found_c;
    logic              accept_ok_c;
    logic              take_c;

    rr_priority_picker #(.N(N)) u_picker (
        .req_i     (req_notify_i),
        .last_i    (last_q),
        .idx_c_o   (win_c),
        .found_c_o (found_c)
    );

    // Register can accept when empty or when it is being drained this cycle.
    always_comb begin
        accept_ok_c = (state_q == ST_IDLE) || b_out_sync_i;
        take_c      = accept_ok_c && found_c && !rst;
        req_sync_o  = '0;
        if (take_c) begin
            req_sync_o[win_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            b_out_q  <= '0;
            notify_q <= 1'b0;
            grant_q  <= '0;
            last_q   <= IDX_W'(N - 1);
        end else if (take_c) begin
            state_q  <= ST_SEND;
            b_out_q  <= req_data_i[32'(win_c) * DATA_W +: DATA_W];
            notify_q <= 1'b1;
            grant_q  <= win_c;
            last_q   <= win_c;
        end else if ((state_q == ST_SEND) && b_out_sync_i) begin
            state_q  <= ST_IDLE;
            notify_q <= 1'b0;
        end
    end

    assign b_out_o        = b_out_q;
    assign b_out_notify_o = notify_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q == ST_SEND);

endmodule
